// File: rtl/input_debounce_if.sv
// Pin-conditioner bus between the board inputs and the core-side consumer.
// The master side drives raw pins, event clears and interrupt enables.
// The slave side (the debouncer) returns the conditioned level, edges,
// sticky events and the interrupt request.
interface input_debounce_if #(
  parameter int N_CH = 21
);
  logic [N_CH-1:0] i_raw;
  logic [N_CH-1:0] i_event_clr;
  logic [N_CH-1:0] i_irq_en;
  logic [N_CH-1:0] o_level;
  logic [N_CH-1:0] o_rise;
  logic [N_CH-1:0] o_fall;
  logic [N_CH-1:0] o_event;
  logic            o_irq;

  modport master (
    output i_raw,
    output i_event_clr,
    output i_irq_en,
    input  o_level,
    input  o_rise,
    input  o_fall,
    input  o_event,
    input  o_irq
  );

  modport slave (
    input  i_raw,
    input  i_event_clr,
    input  i_irq_en,
    output o_level,
    output o_rise,
    output o_fall,
    output o_event,
    output o_irq
  );
endinterface

// File: rtl/input_debounce.sv
// Board input conditioner: per-channel two-stage synchroniser, stability
// counter debounce, one-cycle edge pulses, sticky clearable event flags and
// a maskable interrupt request. Every channel is an identical, independent
// copy; only the interrupt OR combines them.
module input_debounce #(
  parameter int N_CH            = 21,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic               clk,
  input  logic               rst,
  input_debounce_if.slave    bus
);

  // Terminal count: the counter reaches this after DEBOUNCE_CYCLES-1
  // consecutive mismatches; the next mismatch commits the new level.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_CH-1:0] level_vec;
  logic [N_CH-1:0] rise_vec;
  logic [N_CH-1:0] fall_vec;
  logic [N_CH-1:0] event_vec;
  logic            irq_q;
  logic            irq_d;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic             s1_q;
    logic             s2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             rise_q;
    logic             rise_d;
    logic             fall_q;
    logic             fall_d;
    logic             event_q;
    logic             event_d;

    // Debounce decision: count consecutive cycles where the synchronised
    // pin disagrees with the committed level; commit on the final one.
    always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      if (s2_q == stable_q) begin
        // Any agreement, even for one cycle, restarts the window.
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        stable_d = s2_q;
        cnt_d    = '0;
        rise_d   = s2_q;
        fall_d   = ~s2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // Sticky event: a new edge on this cycle beats a simultaneous clear,
    // so software never loses an edge it is in the middle of acknowledging.
    always_comb begin
      event_d = (event_q & ~bus.i_event_clr[gi]) | rise_d | fall_d;
    end

    // Channel state registers; reset discards any partial count.
    always_ff @(posedge clk) begin
      if (rst) begin
        s1_q     <= 1'b0;
        s2_q     <= 1'b0;
        stable_q <= 1'b0;
        cnt_q    <= '0;
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
        event_q  <= 1'b0;
      end else begin
        s1_q     <= bus.i_raw[gi];
        s2_q     <= s1_q;
        stable_q <= stable_d;
        cnt_q    <= cnt_d;
        rise_q   <= rise_d;
        fall_q   <= fall_d;
        event_q  <= event_d;
      end
    end

    assign level_vec[gi] = stable_q;
    assign rise_vec[gi]  = rise_q;
    assign fall_vec[gi]  = fall_q;
    assign event_vec[gi] = event_q;
  end

  // Interrupt looks at the registered events, so it trails them by a cycle.
  always_comb begin
    irq_d = |(event_vec & bus.i_irq_en);
  end

  // Interrupt request register.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign bus.o_level = level_vec;
  assign bus.o_rise  = rise_vec;
  assign bus.o_fall  = fall_vec;
  assign bus.o_event = event_vec;
  assign bus.o_irq   = irq_q;

endmodule

// File: tb/tb_input_debounce.sv
// Bench for input_debounce with a 4-cycle window: a directed vector table,
// hand-written corner sequences, then random pin activity against a
// window-based behavioural model.
module tb_input_debounce;
  localparam int N  = 21;
  localparam int DC = 4;
  localparam logic [N-1:0] B0  = 21'h000001;
  localparam logic [N-1:0] B3  = 21'h000008;
  localparam logic [N-1:0] B5  = 21'h000020;
  localparam logic [N-1:0] B17 = 21'h020000;
  localparam logic [N-1:0] B20 = 21'h100000;
  localparam logic [N-1:0] Z   = 21'h000000;
  localparam logic [N-1:0] ONES = 21'h1FFFFF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  input_debounce_if #(.N_CH(N)) bus_if ();

  input_debounce #(.N_CH(N), .DEBOUNCE_CYCLES(DC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int asserts = 0;
  int fails   = 0;

  // Behavioural model: the level flips once the last DC synchronised
  // samples all disagree with it.
  logic [N-1:0] m_s1, m_s2, m_stable, m_rise, m_fall, m_evt;
  logic         m_irq;
  logic [N-1:0] m_hist [DC];

  task automatic model_step();
    logic [N-1:0] flip;
    logic         irq_n;
    if (rst) begin
      m_s1 = Z; m_s2 = Z; m_stable = Z; m_rise = Z; m_fall = Z; m_evt = Z;
      m_irq = 1'b0;
      for (int j = 0; j < DC; j++) m_hist[j] = Z;
    end else begin
      irq_n = |(m_evt & bus_if.i_irq_en);
      for (int j = DC - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
      m_hist[0] = m_s2;
      flip = ONES;
      for (int j = 0; j < DC; j++) flip = flip & (m_hist[j] ^ m_stable);
      m_rise   = flip & ~m_stable;
      m_fall   = flip & m_stable;
      m_stable = m_stable ^ flip;
      m_evt    = (m_evt & ~bus_if.i_event_clr) | m_rise | m_fall;
      m_irq    = irq_n;
      m_s2     = m_s1;
      m_s1     = bus_if.i_raw;
    end
  endtask

  // One clock: drive inputs, advance the model, sample after the edge.
  task automatic cyc(input logic r, input logic [N-1:0] raw,
                     input logic [N-1:0] clr, input logic [N-1:0] en);
    rst = r;
    bus_if.i_raw = raw;
    bus_if.i_event_clr = clr;
    bus_if.i_irq_en = en;
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [N-1:0] act,
                     input logic [N-1:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [N-1:0] lv,
                         input logic [N-1:0] ri, input logic [N-1:0] fa,
                         input logic [N-1:0] ev, input logic iq);
    chk({tag, ".level"}, bus_if.o_level, lv);
    chk({tag, ".rise"},  bus_if.o_rise,  ri);
    chk({tag, ".fall"},  bus_if.o_fall,  fa);
    chk({tag, ".event"}, bus_if.o_event, ev);
    chk({tag, ".irq"},   {20'd0, bus_if.o_irq}, {20'd0, iq});
  endtask

  typedef struct {
    logic         rst;
    logic [N-1:0] raw, clr, en;
    logic [N-1:0] level, rise, fall, evt;
    logic         irq;
  } vec_t;

  vec_t tbl [24];

  function automatic vec_t mk(logic r, logic [N-1:0] raw, logic [N-1:0] lv,
                              logic [N-1:0] ri, logic [N-1:0] ev, logic iq);
    vec_t v;
    v.rst = r; v.raw = raw; v.clr = Z; v.en = B3;
    v.level = lv; v.rise = ri; v.fall = Z; v.evt = ev; v.irq = iq;
    return v;
  endfunction

  initial begin
    rst = 1'b1;
    bus_if.i_raw = Z; bus_if.i_event_clr = Z; bus_if.i_irq_en = Z;

    // Reset, partial count, reset mid-count, full debounce of channel 3,
    // then a 3-cycle pulse on channel 17 that must be ignored.
    for (int i = 0; i < 2; i++)   tbl[i] = mk(1'b1, Z, Z, Z, Z, 1'b0);
    for (int i = 2; i < 6; i++)   tbl[i] = mk(1'b0, B3, Z, Z, Z, 1'b0);
    for (int i = 6; i < 9; i++)   tbl[i] = mk(1'b1, B3, Z, Z, Z, 1'b0);
    for (int i = 9; i < 14; i++)  tbl[i] = mk(1'b0, B3, Z, Z, Z, 1'b0);
    tbl[14] = mk(1'b0, B3, B3, B3, B3, 1'b0);
    tbl[15] = mk(1'b0, B3, B3, Z, B3, 1'b1);
    for (int i = 16; i < 19; i++) tbl[i] = mk(1'b0, B3 | B17, B3, Z, B3, 1'b1);
    for (int i = 19; i < 24; i++) tbl[i] = mk(1'b0, B3, B3, Z, B3, 1'b1);

    for (int i = 0; i < 24; i++) begin
      cyc(tbl[i].rst, tbl[i].raw, tbl[i].clr, tbl[i].en);
      chk_all($sformatf("vec%0d", i), tbl[i].level, tbl[i].rise,
              tbl[i].fall, tbl[i].evt, tbl[i].irq);
      $display("vec %0d rst=%0d raw=%h level=%h rise=%h event=%h irq=%0d",
               i, tbl[i].rst, tbl[i].raw, bus_if.o_level, bus_if.o_rise,
               bus_if.o_event, bus_if.o_irq);
    end

    // Alternating single-cycle pattern on channel 17, then settle.
    for (int i = 0; i < 26; i++) begin
      cyc(1'b0, B3 | (((i % 2) == 1 && i < 20) ? B17 : Z), Z, B3);
      chk_all("alt", B3, Z, Z, B3, 1'b1);
    end
    $display("alt: 20-cycle toggle on ch17 rejected, level=%h", bus_if.o_level);

    // Channel 5: clear everything, debounce a rise, then clear during fall.
    cyc(1'b0, B3, ONES, B5);
    chk_all("clr_all", B3, Z, Z, Z, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      cyc(1'b0, B3 | B5, Z, B5);
      if (i < 6) chk("ch5_rise_wait", bus_if.o_rise, Z);
    end
    chk_all("ch5_rise", B3 | B5, B5, Z, B5, 1'b0);
    cyc(1'b0, B3 | B5, Z, B5);
    chk_all("ch5_irq", B3 | B5, Z, Z, B5, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b0, B3, Z, B5);
      chk("ch5_fall_wait", bus_if.o_fall, Z);
    end
    cyc(1'b0, B3, B5, B5);
    chk_all("ch5_fall_clr", B3, Z, B5, B5, 1'b1);
    cyc(1'b0, B3, B5, B5);
    chk_all("ch5_clr", B3, Z, Z, Z, 1'b1);
    cyc(1'b0, B3, Z, B5);
    chk_all("ch5_irq_drop", B3, Z, Z, Z, 1'b0);
    $display("ch5: set-wins-over-clear and irq drop sequence done");

    // Channels 0 and 20 together, interrupts masked, then enable ch20.
    for (int i = 1; i <= 6; i++) cyc(1'b0, B3 | B0 | B20, Z, Z);
    chk_all("ch0_20", B3 | B0 | B20, B0 | B20, Z, B0 | B20, 1'b0);
    cyc(1'b0, B3 | B0 | B20, Z, Z);
    chk("ch0_20_masked", {20'd0, bus_if.o_irq}, Z);
    cyc(1'b0, B3 | B0 | B20, Z, B20);
    chk("ch20_en", {20'd0, bus_if.o_irq}, 21'd1);
    $display("ch0/20: events=%h irq=%0d", bus_if.o_event, bus_if.o_irq);

    // Pins high through reset produce one rise DC+2 edges after release.
    cyc(1'b1, ONES, Z, Z);
    cyc(1'b1, ONES, Z, Z);
    chk_all("rst_ones", Z, Z, Z, Z, 1'b0);
    for (int i = 1; i <= DC + 3; i++) begin
      cyc(1'b0, ONES, Z, Z);
      if (i == DC + 2) chk_all("ones_rise", ONES, ONES, Z, ONES, 1'b0);
      else if (i < DC + 2) chk("ones_wait", bus_if.o_rise | bus_if.o_level, Z);
      else chk("ones_after", bus_if.o_rise, Z);
    end
    $display("reset release with pins high: rise=%h", bus_if.o_rise);

    // Random activity against the model.
    begin
      logic [N-1:0] raw, en;
      int rst_left;
      raw = Z; en = $urandom; rst_left = 0;
      for (int i = 0; i < 3000; i++) begin
        raw = raw ^ (N'($urandom) & N'($urandom) & N'($urandom));
        if ($urandom_range(0, 63) == 0) en = N'($urandom);
        if (rst_left == 0 && $urandom_range(0, 299) == 0)
          rst_left = $urandom_range(1, 3);
        cyc(rst_left != 0, raw,
            N'($urandom) & N'($urandom) & N'($urandom) & N'($urandom), en);
        if (rst_left != 0) rst_left--;
        chk_all("rand", m_stable, m_rise, m_fall, m_evt, m_irq);
        if ((i % 250) == 249)
          $display("rand %0d: level=%h event=%h irq=%0d", i,
                   bus_if.o_level, bus_if.o_event, bus_if.o_irq);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             asserts, fails);
    $finish;
  end
endmodule
